mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_starve_cnt.sv | 31 +++
 rtl/mem_arbiter.sv | 109 ++++++++++
 tb/tb_mem_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default constants for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_DATA_WIDTH   = 32;
  localparam int unsigned DEF_ADDR_WIDTH   = 64;
  localparam int unsigned DEF_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_FETCH = 2'd1,
    GNT_DATA  = 2'd2
  } gnt_e;

  // Counter width able to hold 0..limit, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Counts consecutive cycles the fetch port waits; flags when the wait hits the limit.
module mem_arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic arstn,
  input  logic f_req,
  input  logic f_ready,
  output logic starved_c
);

  localparam int unsigned CNT_W = cnt_width(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      cnt <= '0;
    end else if (!f_req || f_ready) begin
      cnt <= '0;
    end else if (cnt != LIMIT) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign starved_c = (cnt == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority (data first) arbiter for fetch/data ports onto one single-port
// memory, with a starvation override for fetch and one-cycle registered responses.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  f_req,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  output logic                  f_ready,
  output logic                  f_rsp_valid,
  output logic [DATA_WIDTH-1:0] f_rsp_data,
  output logic                  f_rsp_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ready,
  output logic                  d_rsp_valid,
  output logic [DATA_WIDTH-1:0] d_rsp_data,
  output logic                  d_rsp_err,
  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  gnt_e                  gnt_c;
  logic                  starved_c;
  logic                  f_misaligned_c;
  logic                  d_misaligned_c;
  logic [ADDR_WIDTH-1:0] last_addr;

  mem_arb_starve_cnt #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk       (clk),
    .arstn     (arstn),
    .f_req     (f_req),
    .f_ready   (f_ready),
    .starved_c (starved_c)
  );

  // Grant decode; reset gates both readies so nothing is accepted while arstn=0.
  always_comb begin
    gnt_c = GNT_NONE;
    if (arstn) begin
      if (f_req && (!d_req || starved_c)) begin
        gnt_c = GNT_FETCH;
      end else if (d_req) begin
        gnt_c = GNT_DATA;
      end
    end
  end

  assign f_ready        = (gnt_c == GNT_FETCH);
  assign d_ready        = (gnt_c == GNT_DATA);
  assign f_misaligned_c = (f_addr[1:0] != 2'b00);
  assign d_misaligned_c = (d_addr[1:0] != 2'b00);

  // Memory address follows the grant; idle cycles park on the last granted address.
  always_comb begin
    mem_addr = last_addr;
    case (gnt_c)
      GNT_FETCH: mem_addr = f_addr;
      GNT_DATA:  mem_addr = d_addr;
      default:   mem_addr = last_addr;
    endcase
  end

  assign mem_write_en   = d_ready && d_we && !d_misaligned_c;
  assign mem_write_data = d_wdata;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      last_addr <= '0;
    end else if (gnt_c != GNT_NONE) begin
      last_addr <= mem_addr;
    end
  end

  // Response registers: valid pulses the cycle after accept; data/err hold otherwise.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      f_rsp_valid <= 1'b0;
      f_rsp_data  <= '0;
      f_rsp_err   <= 1'b0;
      d_rsp_valid <= 1'b0;
      d_rsp_data  <= '0;
      d_rsp_err   <= 1'b0;
    end else begin
      f_rsp_valid <= f_ready;
      d_rsp_valid <= d_ready;
      if (f_ready) begin
        f_rsp_data <= f_misaligned_c ? '0 : mem_read_data;
        f_rsp_err  <= f_misaligned_c;
      end
      if (d_ready) begin
        d_rsp_data <= (d_misaligned_c || d_we) ? '0 : mem_read_data;
        d_rsp_err  <= d_misaligned_c;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table, starvation rotation, mid-stream reset.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        arstn;
  logic        f_req;
  logic [63:0] f_addr;
  logic        f_ready;
  logic        f_rsp_valid;
  logic [31:0] f_rsp_data;
  logic        f_rsp_err;
  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_data;
  logic        d_rsp_err;
  logic        mem_write_en;
  logic [63:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] mem [64];
  logic [5:0]  mem_idx;
  logic        mem_load;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk            (clk),
    .arstn          (arstn),
    .f_req          (f_req),
    .f_addr         (f_addr),
    .f_ready        (f_ready),
    .f_rsp_valid    (f_rsp_valid),
    .f_rsp_data     (f_rsp_data),
    .f_rsp_err      (f_rsp_err),
    .d_req          (d_req),
    .d_we           (d_we),
    .d_addr         (d_addr),
    .d_wdata        (d_wdata),
    .d_ready        (d_ready),
    .d_rsp_valid    (d_rsp_valid),
    .d_rsp_data     (d_rsp_data),
    .d_rsp_err      (d_rsp_err),
    .mem_write_en   (mem_write_en),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  // Simple word memory: combinational read, write on rising edge.
  assign mem_idx       = 6'(mem_addr >> 2);
  assign mem_read_data = mem[mem_idx];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 + 32'(i);
      mem[2] <= 32'hDEAD_BEEF;
    end else if (mem_write_en) begin
      mem[mem_idx] <= mem_write_data;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        f_req;
    logic [63:0] f_addr;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [31:0] d_wdata;
    logic        f_rdy;
    logic        d_rdy;
    logic        we;
    logic [63:0] maddr;
    logic        fv;
    logic [31:0] fd;
    logic        fe;
    logic        dv;
    logic [31:0] dd;
    logic        de;
  } vec_t;

  vec_t vecs [10];

  task automatic drive(input logic fr, input logic [63:0] fa, input logic dr,
                       input logic dw, input logic [63:0] da, input logic [31:0] wd);
    f_req = fr; f_addr = fa; d_req = dr; d_we = dw; d_addr = da; d_wdata = wd;
  endtask

  initial begin
    //         f_req f_addr  d_req d_we  d_addr  d_wdata        f_rdy d_rdy we   maddr   fv   fd             fe   dv   dd             de
    vecs[0] = '{1'b0, 64'h0,  1'b0, 1'b0, 64'h0,  32'h0,         1'b0, 1'b0, 1'b0, 64'h0,  1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0};
    vecs[1] = '{1'b1, 64'h8,  1'b0, 1'b0, 64'h0,  32'h0,         1'b1, 1'b0, 1'b0, 64'h8,  1'b1, 32'hDEADBEEF,  1'b0, 1'b0, 32'h0,         1'b0};
    vecs[2] = '{1'b0, 64'h0,  1'b1, 1'b1, 64'h10, 32'h12345678,  1'b0, 1'b1, 1'b1, 64'h10, 1'b0, 32'hDEADBEEF,  1'b0, 1'b1, 32'h0,         1'b0};
    vecs[3] = '{1'b0, 64'h0,  1'b1, 1'b0, 64'h10, 32'h0,         1'b0, 1'b1, 1'b0, 64'h10, 1'b0, 32'hDEADBEEF,  1'b0, 1'b1, 32'h12345678,  1'b0};
    vecs[4] = '{1'b0, 64'h0,  1'b1, 1'b1, 64'h13, 32'hFFFFFFFF,  1'b0, 1'b1, 1'b0, 64'h13, 1'b0, 32'hDEADBEEF,  1'b0, 1'b1, 32'h0,         1'b1};
    vecs[5] = '{1'b0, 64'h0,  1'b1, 1'b0, 64'h10, 32'h0,         1'b0, 1'b1, 1'b0, 64'h10, 1'b0, 32'hDEADBEEF,  1'b0, 1'b1, 32'h12345678,  1'b0};
    vecs[6] = '{1'b1, 64'h6,  1'b0, 1'b0, 64'h0,  32'h0,         1'b1, 1'b0, 1'b0, 64'h6,  1'b1, 32'h0,         1'b1, 1'b0, 32'h12345678,  1'b0};
    vecs[7] = '{1'b1, 64'h8,  1'b1, 1'b0, 64'h0,  32'h0,         1'b0, 1'b1, 1'b0, 64'h0,  1'b0, 32'h0,         1'b1, 1'b1, 32'hA0000000,  1'b0};
    vecs[8] = '{1'b1, 64'h8,  1'b0, 1'b0, 64'h0,  32'h0,         1'b1, 1'b0, 1'b0, 64'h8,  1'b1, 32'hDEADBEEF,  1'b0, 1'b0, 32'hA0000000,  1'b0};
    vecs[9] = '{1'b0, 64'h0,  1'b0, 1'b0, 64'h0,  32'h0,         1'b0, 1'b0, 1'b0, 64'h8,  1'b0, 32'hDEADBEEF,  1'b0, 1'b0, 32'hA0000000,  1'b0};

    arstn    = 1'b0;
    mem_load = 1'b1;
    drive(1'b1, 64'h8, 1'b1, 1'b1, 64'h4, 32'h1111_1111);
    repeat (3) @(posedge clk);
    #1;
    check("rst f_ready", 64'(f_ready), 64'h0);
    check("rst d_ready", 64'(d_ready), 64'h0);
    check("rst mem_write_en", 64'(mem_write_en), 64'h0);
    check("rst mem_addr", mem_addr, 64'h0);
    check("rst rsp_valid", 64'({f_rsp_valid, d_rsp_valid}), 64'h0);
    check("rst rsp_err", 64'({f_rsp_err, d_rsp_err}), 64'h0);
    check("rst rsp_data", {f_rsp_data, d_rsp_data}, 64'h0);
    mem_load = 1'b0;
    @(negedge clk);
    drive(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 32'h0);
    arstn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(vecs[i].f_req, vecs[i].f_addr, vecs[i].d_req, vecs[i].d_we, vecs[i].d_addr, vecs[i].d_wdata);
      #2;
      check($sformatf("v%0d f_ready", i), 64'(f_ready), 64'(vecs[i].f_rdy));
      check($sformatf("v%0d d_ready", i), 64'(d_ready), 64'(vecs[i].d_rdy));
      check($sformatf("v%0d mem_write_en", i), 64'(mem_write_en), 64'(vecs[i].we));
      check($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].maddr);
      @(posedge clk);
      #1;
      check($sformatf("v%0d f_rsp_valid", i), 64'(f_rsp_valid), 64'(vecs[i].fv));
      check($sformatf("v%0d f_rsp_data", i), 64'(f_rsp_data), 64'(vecs[i].fd));
      check($sformatf("v%0d f_rsp_err", i), 64'(f_rsp_err), 64'(vecs[i].fe));
      check($sformatf("v%0d d_rsp_valid", i), 64'(d_rsp_valid), 64'(vecs[i].dv));
      check($sformatf("v%0d d_rsp_data", i), 64'(d_rsp_data), 64'(vecs[i].dd));
      check($sformatf("v%0d d_rsp_err", i), 64'(d_rsp_err), 64'(vecs[i].de));
    end

    // Both ports held: four data grants, then one forced fetch grant, repeating.
    for (int k = 0; k < 10; k++) begin
      logic exp_f;
      exp_f = ((k % 5) == 4);
      @(negedge clk);
      drive(1'b1, 64'h8, 1'b1, 1'b0, 64'h20, 32'h0);
      #2;
      check($sformatf("starve%0d f_ready", k), 64'(f_ready), 64'(exp_f));
      check($sformatf("starve%0d d_ready", k), 64'(d_ready), 64'(!exp_f));
      @(posedge clk);
      #1;
      check($sformatf("starve%0d f_rsp_valid", k), 64'(f_rsp_valid), 64'(exp_f));
      check($sformatf("starve%0d d_rsp_valid", k), 64'(d_rsp_valid), 64'(!exp_f));
      if (exp_f) check($sformatf("starve%0d f_rsp_data", k), 64'(f_rsp_data), 64'hDEADBEEF);
      else       check($sformatf("starve%0d d_rsp_data", k), 64'(d_rsp_data), 64'hA0000008);
    end

    // Reset asserted mid-cycle while a write to 0x24 is being accepted.
    @(negedge clk);
    drive(1'b1, 64'h8, 1'b1, 1'b1, 64'h24, 32'h5555_5555);
    #2;
    check("mid pre d_ready", 64'(d_ready), 64'h1);
    check("mid pre mem_write_en", 64'(mem_write_en), 64'h1);
    arstn = 1'b0;
    #1;
    check("mid f_ready", 64'(f_ready), 64'h0);
    check("mid d_ready", 64'(d_ready), 64'h0);
    check("mid mem_write_en", 64'(mem_write_en), 64'h0);
    check("mid mem_addr", mem_addr, 64'h0);
    check("mid rsp_valid", 64'({f_rsp_valid, d_rsp_valid}), 64'h0);
    check("mid rsp_err", 64'({f_rsp_err, d_rsp_err}), 64'h0);
    check("mid rsp_data", {f_rsp_data, d_rsp_data}, 64'h0);
    @(posedge clk);
    #1;
    check("mid post rsp_valid", 64'({f_rsp_valid, d_rsp_valid}), 64'h0);
    @(negedge clk);
    drive(1'b1, 64'h8, 1'b1, 1'b0, 64'h24, 32'h0);
    arstn = 1'b1;
    #2;
    check("rel f_ready", 64'(f_ready), 64'h0);
    check("rel d_ready", 64'(d_ready), 64'h1);
    @(posedge clk);
    #1;
    check("rel d_rsp_valid", 64'(d_rsp_valid), 64'h1);
    check("rel d_rsp_data", 64'(d_rsp_data), 64'hA0000009);
    check("rel f_rsp_valid", 64'(f_rsp_valid), 64'h0);
    @(negedge clk);
    drive(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 32'h0);
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
